// File: rtl/clock_period_monitor.sv
// Measures high time, low time and period of an asynchronous square wave in clk cycles,
// with half-period tolerance checking, stuck detection and lock indication.
module clock_period_monitor #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned EXP_HALF = 5,
  parameter int unsigned TOL      = 1,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned LOCK_N   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             err_clr,
  input  logic             sig_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period,
  output logic             meas_valid,
  output logic             half_err,
  output logic             stuck,
  output logic             locked
);

  // state     | meaning
  // IDLE      | disabled, counters idle
  // WAIT_RISE | armed, waiting for first rising edge (falls ignored)
  // HIGH      | counting the high half
  // LOW       | counting the low half
  typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} state_t;

  localparam int unsigned GW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] LO_B  = CNT_W'((EXP_HALF >= TOL) ? (EXP_HALF - TOL) : 0);
  localparam logic [CNT_W-1:0] HI_B  = CNT_W'(EXP_HALF + TOL);
  localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);
  localparam logic [GW-1:0]    LCK_C = GW'(LOCK_N);

  state_t           state_q, state_d;
  logic             s0_q, s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic             hi_ok_q, hi_ok_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d, low_cnt_q, low_cnt_d;
  logic [CNT_W:0]   period_q, period_d;
  logic             mv_q, mv_d, herr_q, herr_d, stuck_q, stuck_d;
  logic [GW-1:0]    good_q, good_d;
  logic             rise, fall, in_tol, tmo, err_set;

  assign rise    = s1_q & ~s2_q;
  assign fall    = ~s1_q & s2_q;
  assign in_tol  = (cnt_q >= LO_B) && (cnt_q <= HI_B);
  assign tmo     = (cnt_q == TO_C);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      cnt_q      <= '0;
      hi_lat_q   <= '0;
      hi_ok_q    <= 1'b0;
      high_cnt_q <= '0;
      low_cnt_q  <= '0;
      period_q   <= '0;
      mv_q       <= 1'b0;
      herr_q     <= 1'b0;
      stuck_q    <= 1'b0;
      good_q     <= '0;
    end else begin
      state_q    <= state_d;
      s0_q       <= sig_in;
      s1_q       <= s0_q;
      s2_q       <= s1_q;
      cnt_q      <= cnt_d;
      hi_lat_q   <= hi_lat_d;
      hi_ok_q    <= hi_ok_d;
      high_cnt_q <= high_cnt_d;
      low_cnt_q  <= low_cnt_d;
      period_q   <= period_d;
      mv_q       <= mv_d;
      herr_q     <= herr_d;
      stuck_q    <= stuck_d;
      good_q     <= good_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      state_d = WAIT_RISE;
        WAIT_RISE: if (rise) state_d = HIGH;
        HIGH:      if (fall) state_d = LOW;  else if (tmo) state_d = WAIT_RISE;
        LOW:       if (rise) state_d = HIGH; else if (tmo) state_d = WAIT_RISE;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    hi_lat_d   = hi_lat_q;
    hi_ok_d    = hi_ok_q;
    high_cnt_d = high_cnt_q;
    low_cnt_d  = low_cnt_q;
    period_d   = period_q;
    mv_d       = 1'b0;
    stuck_d    = stuck_q;
    good_d     = good_q;
    err_set    = 1'b0;
    if (!enable) begin
      cnt_d  = '0;
      good_d = '0;
    end else begin
      case (state_q)
        IDLE: cnt_d = '0;
        WAIT_RISE: if (rise) cnt_d = CNT_W'(1);
        HIGH: begin
          if (fall) begin
            hi_lat_d = cnt_q;
            hi_ok_d  = in_tol;
            cnt_d    = CNT_W'(1);
            if (!in_tol) begin
              err_set = 1'b1;
              good_d  = '0;
            end
          end else if (tmo) begin
            stuck_d = 1'b1;
            good_d  = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        LOW: begin
          if (rise) begin
            high_cnt_d = hi_lat_q;
            low_cnt_d  = cnt_q;
            period_d   = {1'b0, hi_lat_q} + {1'b0, cnt_q};
            mv_d       = 1'b1;
            stuck_d    = 1'b0;
            cnt_d      = CNT_W'(1);
            if (!in_tol) begin
              err_set = 1'b1;
              good_d  = '0;
            end else if (hi_ok_q && (good_q != LCK_C)) begin
              good_d = good_q + 1'b1;
            end
          end else if (tmo) begin
            stuck_d = 1'b1;
            good_d  = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: cnt_d = '0;
      endcase
    end
    // a new error outranks a simultaneous clear
    herr_d = err_set ? 1'b1 : (err_clr ? 1'b0 : herr_q);
  end

  always_comb begin
    high_cnt   = high_cnt_q;
    low_cnt    = low_cnt_q;
    period     = period_q;
    meas_valid = mv_q;
    half_err   = herr_q;
    stuck      = stuck_q;
    locked     = (good_q == LCK_C);
  end

endmodule

// File: tb/tb_clock_period_monitor.sv
// Directed bench for clock_period_monitor: nominal, tolerance, stuck, error-clear and enable/reset.
module tb_clock_period_monitor;

  logic        clk = 1'b0;
  logic        rst, enable, err_clr, sig_in;
  logic [15:0] high_cnt, low_cnt;
  logic [16:0] period;
  logic        meas_valid, half_err, stuck, locked;

  int n_chk = 0;
  int n_err = 0;

  int   h_mv, h_hi, h_lo, h_per, h_stuck_i, h_err_i;
  logic h_locked, h_stuck, h_herr, h_err_lock, h_err_lock_prev;
  logic err_prev = 1'b0;
  logic lock_prev = 1'b0;

  clock_period_monitor dut (
    .clk(clk), .rst(rst), .enable(enable), .err_clr(err_clr), .sig_in(sig_in),
    .high_cnt(high_cnt), .low_cnt(low_cnt), .period(period),
    .meas_valid(meas_valid), .half_err(half_err), .stuck(stuck), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive sig_in=val for n cycles (starting at a negedge); err_clr is high during the
  // cycle ending at posedge clr_at (0 = never). Samples outputs at each negedge.
  task automatic half(input logic val, input int n, input int clr_at);
    sig_in  = val;
    err_clr = (clr_at == 1);
    h_mv = 0; h_stuck_i = 0; h_err_i = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      err_clr = (i + 1 == clr_at);
      @(negedge clk);
      if (meas_valid) begin
        h_mv++;
        h_hi = high_cnt; h_lo = low_cnt; h_per = period;
        h_locked = locked; h_stuck = stuck; h_herr = half_err;
      end
      if (stuck && h_stuck_i == 0) h_stuck_i = i;
      if (half_err && !err_prev && h_err_i == 0) begin
        h_err_i = i; h_err_lock = locked; h_err_lock_prev = lock_prev;
      end
      lock_prev = locked;
      err_prev  = half_err;
    end
  endtask

  task automatic chk_meas(input string tag, input int hi, input int lo);
    chk({tag, "_mv"}, h_mv, 1);
    chk({tag, "_hi"}, h_hi, hi);
    chk({tag, "_lo"}, h_lo, lo);
    chk({tag, "_per"}, h_per, hi + lo);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hi"}, high_cnt, 0);
    chk({tag, "_lo"}, low_cnt, 0);
    chk({tag, "_per"}, period, 0);
    chk({tag, "_flags"}, {meas_valid, half_err, stuck, locked}, 0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; err_clr = 1'b0; sig_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0; enable = 1'b1;
    @(negedge clk);

    // nominal 5/5
    for (int i = 0; i < 6; i++) begin
      half(1'b1, 5, 0);
      if (i > 0) begin
        chk_meas($sformatf("nom%0d", i), 5, 5);
        chk($sformatf("nom%0d_locked", i), h_locked, (i >= 4));
      end
      half(1'b0, 5, 0);
    end
    chk("nom_herr", half_err, 0);
    chk("nom_stuck", stuck, 0);

    // tolerance edges
    half(1'b1, 6, 0);
    half(1'b0, 4, 0);
    half(1'b1, 7, 0);
    chk_meas("tol64", 6, 4);
    chk("tol64_herr", h_herr, 0);
    chk("tol64_locked", h_locked, 1);
    half(1'b0, 5, 0);
    chk("tol7_err_at", h_err_i, 3);
    chk("tol7_lock_before", h_err_lock_prev, 1);
    chk("tol7_lock_drop", h_err_lock, 0);
    for (int k = 1; k <= 4; k++) begin
      half(1'b1, 5, 0);
      if (k == 1) chk_meas("tol75", 7, 5);
      chk($sformatf("relock%0d_locked", k), h_locked, 0);
      half(1'b0, 5, 0);
    end
    half(1'b1, 5, 0);
    chk("relock_final", h_locked, 1);

    // stuck high
    half(1'b1, 80, 0);
    chk("stuck_at", h_stuck_i, 62);
    chk("stuck_no_mv", h_mv, 0);
    chk("stuck_flag", stuck, 1);
    chk("stuck_locked", locked, 0);
    half(1'b0, 5, 0);
    half(1'b1, 5, 0);
    chk("wait_rise_no_mv", h_mv, 0);
    chk("wait_rise_stuck", stuck, 1);
    half(1'b0, 5, 0);
    half(1'b1, 5, 0);
    chk_meas("resume", 5, 5);
    chk("resume_stuck", h_stuck, 0);

    // error clear, alone and racing a new error
    chk("clr_pre_herr", half_err, 1);
    half(1'b0, 8, 5);
    chk("clr_alone", half_err, 0);
    half(1'b1, 5, 3);
    chk_meas("clr_race", 5, 8);
    chk("clr_race_err_at", h_err_i, 3);
    chk("clr_race_herr", half_err, 1);

    // enable drop mid-HIGH, then reset
    half(1'b0, 5, 0);
    half(1'b1, 5, 0);
    chk_meas("pre_dis", 5, 5);
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("dis_hi", high_cnt, 5);
    chk("dis_lo", low_cnt, 5);
    chk("dis_per", period, 10);
    chk("dis_locked", locked, 0);
    chk("dis_mv", meas_valid, 0);
    sig_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0; enable = 1'b1;
    half(1'b0, 5, 0);
    half(1'b1, 5, 0);
    chk("reen_first_rise_mv", h_mv, 0);
    half(1'b0, 5, 0);
    half(1'b1, 5, 0);
    chk_meas("reen", 5, 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/clock_period_monitor.md
Name: clock_period_monitor

Overview:
- Receiving-end checker for the square-wave clocks our testbench generators produce. It measures an asynchronous input square wave `sig_in` in `clk` cycles.
- Reports the high time, low time and period of `sig_in`.
- Flags half-periods that fall outside tolerance, flags a stuck input, and asserts `locked` once the input has been stable for long enough.
- Intended uses: on-chip clock health checks, and self-checking benches.

Parameters:
- CNT_W, 16: width of the high/low counters.
- EXP_HALF, 5: expected half-period, in clk cycles.
- TOL, 1: allowed deviation (±) from EXP_HALF, in clk cycles.
- TIMEOUT, 64: cycle count at which a half-period is declared stuck; must be less than 2^CNT_W.
- LOCK_N, 4: number of consecutive good periods required to assert locked.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  measurement enable.
- err_clr  input  1  single-cycle clear of the sticky half_err flag.
- sig_in  input  1  asynchronous square wave under test.
- high_cnt  output  CNT_W  last measured high time.
- low_cnt  output  CNT_W  last measured low time.
- period  output  CNT_W+1  high_cnt + low_cnt of the last complete period.
- meas_valid  output  1  one-cycle pulse when high_cnt, low_cnt and period update together.
- half_err  output  1  sticky: a half-period was outside EXP_HALF±TOL.
- stuck  output  1  no edge seen within TIMEOUT cycles.
- locked  output  1  LOCK_N consecutive in-tolerance periods have been seen.

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: all outputs 0, all internal registers 0, FSM in IDLE.
- Synchronizer: 2-flop synchronizer s0→s1, plus a delay flop s2.
  - rise = s1 & ~s2; fall = ~s1 & s2.
  - Fixed latency of 2–3 clk from sig_in to the edge pulse. Counts are edge-to-edge, so this latency does not affect them.
- FSM states: IDLE, WAIT_RISE, HIGH, LOW.
  - IDLE: stays here while enable=0. On enable=1 → WAIT_RISE.
  - WAIT_RISE: fall is ignored. On rise → HIGH with cnt=1.
  - HIGH:
    - No edge: cnt increments.
    - On fall: high_cnt is latched as cnt (the latch is held internally until the period completes); → LOW with cnt=1.
  - LOW:
    - No edge: cnt increments.
    - On rise: high_cnt, low_cnt and period update; meas_valid=1 for one cycle; → HIGH with cnt=1.
  - Any state: enable=0 → IDLE next cycle. On entering IDLE: locked and cnt clear; high_cnt, low_cnt, period, half_err and stuck hold their values.
- Timeout: in HIGH or LOW, if cnt==TIMEOUT and no edge occurs this cycle:
  - stuck=1, locked=0, → WAIT_RISE.
  - The partial measurement is discarded; no meas_valid is issued.
  - stuck clears on the next meas_valid.
- Half-period checks:
  - Each half (high on fall, low on rise) is checked when it is latched.
  - A half is in tolerance when EXP_HALF−TOL ≤ cnt ≤ EXP_HALF+TOL, compared unsigned. If EXP_HALF < TOL, the lower bound clamps to 0.
  - Out of tolerance → half_err=1 (sticky) and the good-period counter resets to 0; locked drops on that same cycle.
- Lock:
  - The good-period counter increments on each meas_valid where both halves were in tolerance, and saturates at LOCK_N.
  - locked=1 when the counter reaches LOCK_N.
- Error clear:
  - err_clr clears half_err.
  - If a new error and err_clr occur in the same cycle, the error wins and half_err stays 1.
- Arithmetic:
  - cnt saturates at all-ones. Saturation is unreachable given the TIMEOUT constraint.
  - period is computed at full CNT_W+1 width, so it cannot overflow.
- Reset mid-measurement: everything returns to reset values on the next edge. There is no partial meas_valid.
- Simultaneous edges: rise and fall are mutually exclusive by construction.

Test Plan:
- Nominal: enable=1, sig_in toggles every 5 clk.
  - Required: meas_valid every 10 clk with high_cnt=5, low_cnt=5, period=10.
  - locked=1 on the 4th meas_valid; half_err=0; stuck=0.
- Tolerance edges: high=6/low=4 → no error. Then high=7/low=5 → half_err=1 on the fall that latches 7, and locked drops the same cycle. Then 4 good periods → locked re-asserts.
- Stuck: sig_in held high after a rise.
  - Required: stuck=1 when cnt reaches 64, locked=0, FSM in WAIT_RISE, no meas_valid.
  - Resuming the 5/5 toggling → stuck clears on the first meas_valid.
- Error clear race: pulse err_clr alone → half_err clears to 0. Then pulse err_clr in the same cycle a low=8 half is latched → half_err remains 1.
- Enable and reset mid-operation: enable=0 mid-HIGH → IDLE; high_cnt, low_cnt and period hold (5,5,10); locked=0. Then assert rst → all outputs 0 on the next edge. Re-enable → the first meas_valid comes only after a full rise→rise period.
